wb_burst_master: RTL and testbench

Parametrised Wishbone classic master driven by the team's simple command interface (start/address/selection/write/data_wr/data_rd/active). It extends single-transfer command bridging with:
- configurable data and address widths
- incrementing bursts of 1..2^LEN_W beats
- bus-error capture
- per-beat watchdog timeout

It sits between test/control logic and the Wishbone DSP fabric, in place of the single-transfer master inside top.

---
 rtl/wb_burst_master_if.sv | 44 ++++
 rtl/wb_burst_master.sv | 120 ++++++++++++
 tb/tb_wb_burst_master.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_burst_master_if.sv
// Command-side and Wishbone-side signal bundle for wb_burst_master.
// The master modport is the DUT view; the slave modport is the driver/responder view.
interface wb_burst_master_if #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int LEN_W = 4
);
  logic            start;
  logic [AW-1:0]   address;
  logic [DW/8-1:0] selection;
  logic            write;
  logic [DW-1:0]   data_wr;
  logic [LEN_W-1:0] burst_len;
  logic [DW-1:0]   data_rd;
  logic            rd_valid;
  logic            wr_next;
  logic            active;
  logic            done;
  logic            error;
  logic            timeout;
  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic            wb_we_o;
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_ack_i;
  logic            wb_err_i;

  modport master (
    input  start, address, selection, write, data_wr, burst_len,
    input  wb_dat_i, wb_ack_i, wb_err_i,
    output data_rd, rd_valid, wr_next, active, done, error, timeout,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );

  modport slave (
    output start, address, selection, write, data_wr, burst_len,
    output wb_dat_i, wb_ack_i, wb_err_i,
    input  data_rd, rd_valid, wr_next, active, done, error, timeout,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone classic burst master: incrementing bursts, error capture, per-beat watchdog.
// state  | meaning
// IDLE   | waiting for start
// BUS    | cyc/stb high, waiting for ack/err or watchdog expiry
// GAP    | one cycle with stb low, address step, next write data load
// DONE   | one-cycle done pulse, bus released
module wb_burst_master #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic wb_clk,
  input  logic wb_rst,
  wb_burst_master_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Down-counter loaded with TIMEOUT-1 so expiry lands on the TIMEOUT-th BUS cycle
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]       state;
  logic [LEN_W-1:0] beats_left;
  logic [WD_W-1:0]  wd_cnt;
  logic             wd_expired;

  assign wd_expired = (TIMEOUT != 0) && (wd_cnt == '0);

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state        <= S_IDLE;
      beats_left   <= '0;
      wd_cnt       <= '0;
      bus.data_rd  <= '0;
      bus.rd_valid <= 1'b0;
      bus.wr_next  <= 1'b0;
      bus.active   <= 1'b0;
      bus.done     <= 1'b0;
      bus.error    <= 1'b0;
      bus.timeout  <= 1'b0;
      bus.wb_adr_o <= '0;
      bus.wb_dat_o <= '0;
      bus.wb_sel_o <= '0;
      bus.wb_we_o  <= 1'b0;
      bus.wb_cyc_o <= 1'b0;
      bus.wb_stb_o <= 1'b0;
    end else begin
      bus.rd_valid <= 1'b0;
      bus.wr_next  <= 1'b0;
      bus.done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.wb_adr_o <= bus.address;
            bus.wb_sel_o <= bus.selection;
            bus.wb_we_o  <= bus.write;
            bus.wb_dat_o <= bus.data_wr;
            bus.wb_cyc_o <= 1'b1;
            bus.wb_stb_o <= 1'b1;
            bus.active   <= 1'b1;
            bus.error    <= 1'b0;
            bus.timeout  <= 1'b0;
            beats_left   <= bus.burst_len;
            wd_cnt       <= WD_LOAD;
            state        <= S_BUS;
          end
        end
        S_BUS: begin
          if (bus.wb_err_i || bus.wb_ack_i || wd_expired) begin
            if (bus.wb_err_i) begin
              bus.error <= 1'b1;
            end else if (bus.wb_ack_i) begin
              if (!bus.wb_we_o) begin
                bus.data_rd  <= bus.wb_dat_i;
                bus.rd_valid <= 1'b1;
              end
            end else begin
              bus.timeout <= 1'b1;
            end
            if (bus.wb_ack_i && !bus.wb_err_i && beats_left != '0) begin
              bus.wr_next  <= bus.wb_we_o;
              bus.wb_stb_o <= 1'b0;
              beats_left   <= beats_left - LEN_W'(1);
              state        <= S_GAP;
            end else begin
              bus.wb_cyc_o <= 1'b0;
              bus.wb_stb_o <= 1'b0;
              bus.active   <= 1'b0;
              bus.done     <= 1'b1;
              state        <= S_DONE;
            end
          end else begin
            wd_cnt <= wd_cnt - WD_W'(1);
          end
        end
        S_GAP: begin
          bus.wb_adr_o <= bus.wb_adr_o + AW'(DW / 8);
          if (bus.wb_we_o) begin
            bus.wb_dat_o <= bus.data_wr;
          end
          bus.wb_stb_o <= 1'b1;
          wd_cnt       <= WD_LOAD;
          state        <= S_BUS;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: table of bursts against a scoreboarded slave model,
// plus hand sequences for address wrap, ignored start, unlimited wait and async reset.
module tb_wb_burst_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  wb_burst_master_if #(.DW(32), .AW(32), .LEN_W(4)) ba ();
  wb_burst_master_if #(.DW(32), .AW(8),  .LEN_W(4)) bb ();

  wb_burst_master #(.DW(32), .AW(32), .LEN_W(4), .TIMEOUT(8)) dut_a (
    .wb_clk(clk), .wb_rst(rst), .bus(ba));
  wb_burst_master #(.DW(32), .AW(8), .LEN_W(4), .TIMEOUT(0)) dut_b (
    .wb_clk(clk), .wb_rst(rst), .bus(bb));

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [3:0]  sel;
    int          delay;     // stb cycles before ack; >=255 means never ack
    int          err_beat;  // 0-based beat that gets err with ack; -1 none
    logic [31:0] dbase;
  } vec_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } beat_t;

  vec_t        vecs[6];
  beat_t       exp_q[$];
  logic [31:0] rd_q[$];
  logic        prev_err = 1'b0;
  logic        prev_to  = 1'b0;

  function automatic logic [31:0] bdat(input logic [31:0] base, input int i);
    return base + 32'(i) * 32'h11;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v);
    int beats, exp_nwr, exp_nrd, exp_stb;
    int beat = 0, waitc = 0, nstb = 0, nwr = 0, nrd = 0, ncyc = 0;
    bit to, fin = 0;
    beat_t b;
    to      = (v.delay >= 255);
    beats   = (v.err_beat >= 0) ? v.err_beat + 1 : (to ? 1 : int'(v.len) + 1);
    exp_nwr = !v.wr ? 0 : ((v.err_beat >= 0) ? v.err_beat : (to ? 0 : int'(v.len)));
    exp_nrd = v.wr ? 0 : ((v.err_beat >= 0) ? v.err_beat : (to ? 0 : int'(v.len) + 1));
    exp_stb = to ? 8 : beats * (v.delay + 1);
    for (int i = 0; i < beats; i++) begin
      b.adr = v.addr + 32'(4 * i);
      b.dat = bdat(v.dbase, i);
      exp_q.push_back(b);
    end
    @(negedge clk);
    check("sticky_error", ba.error, prev_err);
    check("sticky_timeout", ba.timeout, prev_to);
    ba.start = 1'b1; ba.address = v.addr; ba.selection = v.sel;
    ba.write = v.wr; ba.burst_len = v.len; ba.data_wr = bdat(v.dbase, 0);
    @(negedge clk);
    ba.start = 1'b0;
    check("active_after_start", ba.active, 1);
    check("error_cleared", ba.error, 0);
    check("timeout_cleared", ba.timeout, 0);
    while (!fin && ncyc < 200) begin
      if (ba.rd_valid) begin
        nrd++;
        if (rd_q.size() > 0) check("data_rd", ba.data_rd, rd_q.pop_front());
        else check("rd_valid_unexpected", ba.rd_valid, 0);
      end
      if (ba.wr_next) begin
        nwr++;
        ba.data_wr = bdat(v.dbase, beat);
      end
      if (ba.done) begin
        fin = 1;
        ba.wb_ack_i = 1'b0; ba.wb_err_i = 1'b0;
        check("cyc_at_done", ba.wb_cyc_o, 0);
        check("active_at_done", ba.active, 0);
      end else if (ba.wb_stb_o) begin
        nstb++;
        if (waitc == 0) begin
          if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check("wb_adr_o", ba.wb_adr_o, b.adr);
            if (v.wr) check("wb_dat_o", ba.wb_dat_o, b.dat);
            check("wb_we_o", ba.wb_we_o, v.wr);
            check("wb_sel_o", ba.wb_sel_o, v.sel);
          end else begin
            check("beat_unexpected", ba.wb_stb_o, 0);
          end
        end
        if (!to && waitc == v.delay) begin
          ba.wb_ack_i = 1'b1;
          ba.wb_err_i = (beat == v.err_beat);
          ba.wb_dat_i = bdat(v.dbase, beat);
          if (!v.wr && beat != v.err_beat) rd_q.push_back(bdat(v.dbase, beat));
          beat++;
          waitc = 0;
        end else begin
          ba.wb_ack_i = 1'b0;
          waitc++;
        end
      end else begin
        ba.wb_ack_i = 1'b0; ba.wb_err_i = 1'b0;
        check("gap_cyc", ba.wb_cyc_o, 1);
      end
      if (!fin) begin
        @(negedge clk);
        ncyc++;
      end
    end
    check("done_seen", fin, 1);
    check("wr_next_count", nwr, exp_nwr);
    check("rd_valid_count", nrd, exp_nrd);
    check("stb_cycles", nstb, exp_stb);
    check("error_flag", ba.error, (v.err_beat >= 0));
    check("timeout_flag", ba.timeout, to);
    check("beats_left_unused", exp_q.size(), 0);
    check("reads_left_unseen", rd_q.size(), 0);
    exp_q.delete();
    rd_q.delete();
    prev_err = (v.err_beat >= 0);
    prev_to  = to;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int hi, extra;
    vec_t sv;
    vecs[0] = '{wr:1'b1, addr:32'h100, len:4'd0, sel:4'hF, delay:2,   err_beat:-1, dbase:32'hDEADBEEF};
    vecs[1] = '{wr:1'b0, addr:32'h200, len:4'd3, sel:4'hF, delay:0,   err_beat:-1, dbase:32'h11};
    vecs[2] = '{wr:1'b1, addr:32'h300, len:4'd3, sel:4'hF, delay:1,   err_beat:1,  dbase:32'hCAFE0000};
    vecs[3] = '{wr:1'b0, addr:32'h500, len:4'd0, sel:4'hF, delay:255, err_beat:-1, dbase:32'h0};
    vecs[4] = '{wr:1'b1, addr:32'h600, len:4'd2, sel:4'h3, delay:0,   err_beat:-1, dbase:32'h12345678};
    vecs[5] = '{wr:1'b0, addr:32'h700, len:4'd1, sel:4'hC, delay:3,   err_beat:0,  dbase:32'hAA};

    ba.start = 0; ba.address = '0; ba.selection = '0; ba.write = 0; ba.data_wr = '0;
    ba.burst_len = '0; ba.wb_dat_i = '0; ba.wb_ack_i = 0; ba.wb_err_i = 0;
    bb.start = 0; bb.address = '0; bb.selection = '0; bb.write = 0; bb.data_wr = '0;
    bb.burst_len = '0; bb.wb_dat_i = '0; bb.wb_ack_i = 0; bb.wb_err_i = 0;

    repeat (3) @(negedge clk);
    check("reset_cyc", ba.wb_cyc_o, 0);
    check("reset_stb", ba.wb_stb_o, 0);
    check("reset_active", ba.active, 0);
    check("reset_done", ba.done, 0);
    check("reset_flags", {ba.error, ba.timeout}, 0);
    check("reset_adr", ba.wb_adr_o, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_burst(vecs[i]);

    // Wrap at AW=8, ignored start pulses, and an ack that arrives only after a long wait
    @(negedge clk);
    bb.start = 1; bb.address = 8'hFC; bb.burst_len = 4'd1; bb.write = 0; bb.selection = 4'hF;
    @(negedge clk);
    bb.start = 0;
    check("b_adr_beat0", bb.wb_adr_o, 8'hFC);
    check("b_stb_beat0", bb.wb_stb_o, 1);
    bb.wb_ack_i = 1; bb.wb_dat_i = 32'hA5;
    bb.start = 1; bb.address = 8'h10;
    @(negedge clk);
    bb.start = 0; bb.wb_ack_i = 0;
    check("b_gap_stb", {bb.wb_cyc_o, bb.wb_stb_o}, 2'b10);
    check("b_rd_valid0", bb.rd_valid, 1);
    check("b_data_rd0", bb.data_rd, 32'hA5);
    @(negedge clk);
    check("b_adr_wrap", bb.wb_adr_o, 8'h00);
    hi = 0;
    repeat (300) begin
      @(negedge clk);
      if (bb.wb_stb_o && !bb.done && !bb.timeout) hi++;
    end
    check("b_unlimited_wait", hi, 300);
    bb.wb_ack_i = 1; bb.wb_dat_i = 32'h5A;
    @(negedge clk);
    bb.wb_ack_i = 0;
    bb.start = 1;
    check("b_done", bb.done, 1);
    check("b_rd_valid1", bb.rd_valid, 1);
    check("b_data_rd1", bb.data_rd, 32'h5A);
    check("b_timeout", bb.timeout, 0);
    @(negedge clk);
    bb.start = 0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bb.wb_cyc_o || bb.wb_stb_o) extra++;
    end
    check("b_no_extra_burst", extra, 0);

    // Asynchronous reset in the third beat of a four-beat read
    @(negedge clk);
    ba.start = 1; ba.address = 32'h400; ba.burst_len = 4'd3; ba.write = 0; ba.selection = 4'hF;
    @(negedge clk);
    ba.start = 0;
    for (int k = 0; k < 2; k++) begin
      ba.wb_ack_i = 1;
      @(negedge clk);
      ba.wb_ack_i = 0;
      @(negedge clk);
    end
    check("pre_reset_stb", ba.wb_stb_o, 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_cyc", ba.wb_cyc_o, 0);
    check("async_reset_stb", ba.wb_stb_o, 0);
    check("async_reset_active", ba.active, 0);
    @(negedge clk);
    rst = 1'b0;
    prev_err = 1'b0;
    prev_to  = 1'b0;
    sv = '{wr:1'b0, addr:32'h800, len:4'd0, sel:4'hF, delay:1, err_beat:-1, dbase:32'h77};
    run_burst(sv);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
